// File: rtl/sram_bus_if.sv
// sram_bus_if: request/ready handshake plus SRAM strobes and address.
// The bidirectional data bus stays a plain inout on the master.
interface sram_bus_if #(
    parameter int B  = 15,
    parameter int AW = 10
);
    logic          req;
    logic          wr;
    logic [AW-1:0] addr_in;
    logic [B:0]    wdata;
    logic          ready;
    logic [B:0]    rdata;
    logic          rvalid;
    logic [AW-1:0] sram_addr;
    logic          ncs;
    logic          noe;
    logic          nwe;

    modport master (
        input  req, wr, addr_in, wdata,
        output ready, rdata, rvalid,
        output sram_addr, ncs, noe, nwe
    );

    modport slave (
        output req, wr, addr_in, wdata,
        input  ready, rdata, rvalid,
        input  sram_addr, ncs, noe, nwe
    );
endinterface

// File: rtl/sram_bus_master.sv
// sram_bus_master: single-word request/ready to async SRAM bus cycles.
// Define SRAM_BUS_TURNAROUND_EN to add a deselected turn cycle after HOLD.
module sram_bus_master #(
    parameter int B     = 15,
    parameter int AW    = 10,
    parameter int SETUP = 1,
    parameter int PULSE = 2,
    parameter int HOLD  = 1
) (
    input  logic       clk,
    input  logic       reset,
    sram_bus_if.master bus,
    inout  wire [B:0]  sram_data
);
    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_PULSE,
        ST_HOLD,
        ST_TURN
    } state_t;

    localparam logic [3:0] SETUP_LD = 4'(SETUP - 1);
    localparam logic [3:0] PULSE_LD = 4'(PULSE - 1);
    localparam logic [3:0] HOLD_LD  = 4'(HOLD - 1);

    state_t        state, state_nx;
    logic [3:0]    cnt, cnt_nx;
    logic          wr_q, wr_nx;
    logic [AW-1:0] addr_q;
    logic [B:0]    wdata_q;
    logic [B:0]    rdata_q;
    logic          rvalid_q, rvalid_d;
    logic          ready_q;
    logic          ncs_q, noe_q, nwe_q;
    logic          drive_q;
    logic          accept, last, busy_nx, capture;

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        accept   = 1'b0;
        last     = (cnt == 4'd0);
        unique case (state)
            ST_IDLE: begin
                if (bus.req && ready_q) begin
                    accept   = 1'b1;
                    state_nx = ST_SETUP;
                    cnt_nx   = SETUP_LD;
                end
            end
            ST_SETUP: begin
                if (last) begin
                    state_nx = ST_PULSE;
                    cnt_nx   = PULSE_LD;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            ST_PULSE: begin
                if (last) begin
                    state_nx = ST_HOLD;
                    cnt_nx   = HOLD_LD;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            ST_HOLD: begin
                if (last) begin
`ifdef SRAM_BUS_TURNAROUND_EN
                    state_nx = ST_TURN;
`else
                    state_nx = ST_IDLE;
`endif
                    cnt_nx = 4'd0;
                end else begin
                    cnt_nx = cnt - 4'd1;
                end
            end
            ST_TURN: begin
                state_nx = ST_IDLE;
                cnt_nx   = 4'd0;
            end
            default: begin
                state_nx = ST_IDLE;
                cnt_nx   = 4'd0;
            end
        endcase
    end

    // Strobes are registered from the next state so they change on the edge.
    always_comb begin
        wr_nx   = accept ? bus.wr : wr_q;
        busy_nx = (state_nx == ST_SETUP) || (state_nx == ST_PULSE) ||
                  (state_nx == ST_HOLD);
        capture = (state == ST_PULSE) && last && !wr_q;
`ifdef SRAM_BUS_TURNAROUND_EN
        rvalid_d = (state == ST_TURN) && !wr_q;
`else
        rvalid_d = (state == ST_HOLD) && last && !wr_q;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= ST_IDLE;
            cnt      <= 4'd0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            rvalid_q <= 1'b0;
            ready_q  <= 1'b1;
            ncs_q    <= 1'b1;
            noe_q    <= 1'b1;
            nwe_q    <= 1'b1;
            drive_q  <= 1'b0;
        end else begin
            state    <= state_nx;
            cnt      <= cnt_nx;
            wr_q     <= wr_nx;
            rvalid_q <= rvalid_d;
            ready_q  <= (state_nx == ST_IDLE);
            ncs_q    <= !busy_nx;
            noe_q    <= !((state_nx == ST_PULSE) && !wr_nx);
            nwe_q    <= !((state_nx == ST_PULSE) && wr_nx);
            drive_q  <= busy_nx && wr_nx;
            if (accept) begin
                addr_q  <= bus.addr_in;
                wdata_q <= bus.wdata;
            end
            if (capture) begin
                rdata_q <= sram_data;
            end
        end
    end

    assign sram_data     = drive_q ? wdata_q : 'z;
    assign bus.ready     = ready_q;
    assign bus.rdata     = rdata_q;
    assign bus.rvalid    = rvalid_q;
    assign bus.sram_addr = addr_q;
    assign bus.ncs       = ncs_q;
    assign bus.noe       = noe_q;
    assign bus.nwe       = nwe_q;
endmodule

// File: tb/tb_sram_bus_master.sv
// tb_sram_bus_master: directed vector table plus reset and timing sequences.
// A second instance runs with SETUP=3, PULSE=4, HOLD=2.
module tb_sram_bus_master;
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    sram_bus_if #(.B(15), .AW(10)) bus_a ();
    sram_bus_if #(.B(15), .AW(10)) bus_b ();
    wire  [15:0] data_a;
    wire  [15:0] data_b;
    logic [15:0] sd_a = 16'h0;
    logic [15:0] sd_b = 16'h0;

    // Slave models drive the bus only while output enable is low.
    assign data_a = (bus_a.noe == 1'b0) ? sd_a : 'z;
    assign data_b = (bus_b.noe == 1'b0) ? sd_b : 'z;

    sram_bus_master #(
        .B(15), .AW(10), .SETUP(1), .PULSE(2), .HOLD(1)
    ) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a), .sram_data(data_a)
    );

    sram_bus_master #(
        .B(15), .AW(10), .SETUP(3), .PULSE(4), .HOLD(2)
    ) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b), .sram_data(data_b)
    );

    typedef struct {
        logic        req, wr;
        logic [9:0]  addr;
        logic [15:0] wdata, sd;
        logic        ncs, noe, nwe, rdy, rv, drv;
        logic [9:0]  ea;
        logic [15:0] erd, ed;
    } vec_t;

    vec_t tbl[$];

    task automatic row(input logic req, wr, input logic [9:0] addr,
                       input logic [15:0] wdata, sd,
                       input logic ncs, noe, nwe, rdy, rv, drv,
                       input logic [9:0] ea, input logic [15:0] erd, ed);
        vec_t v;
        v.req = req; v.wr = wr; v.addr = addr; v.wdata = wdata; v.sd = sd;
        v.ncs = ncs; v.noe = noe; v.nwe = nwe; v.rdy = rdy; v.rv = rv;
        v.drv = drv; v.ea = ea; v.erd = erd; v.ed = ed;
        tbl.push_back(v);
    endtask

    task automatic chk(input string nm, input int idx,
                       input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %h want %h", nm, idx, act, exp);
        end
    endtask

    task automatic chk_idle_reset(input string tag);
        chk({tag, "_ncs"}, 0, 32'(bus_a.ncs), 32'd1);
        chk({tag, "_noe"}, 0, 32'(bus_a.noe), 32'd1);
        chk({tag, "_nwe"}, 0, 32'(bus_a.nwe), 32'd1);
        chk({tag, "_ready"}, 0, 32'(bus_a.ready), 32'd1);
        chk({tag, "_rvalid"}, 0, 32'(bus_a.rvalid), 32'd0);
        chk({tag, "_drive"}, 0, 32'(dut_a.drive_q), 32'd0);
        chk({tag, "_rdata"}, 0, 32'(bus_a.rdata), 32'd0);
        chk({tag, "_addr"}, 0, 32'(bus_a.sram_addr), 32'd0);
    endtask

    initial begin
        int got;
        int rv_exp;
        bus_a.req = 0; bus_a.wr = 0; bus_a.addr_in = '0; bus_a.wdata = '0;
        bus_b.req = 0; bus_b.wr = 0; bus_b.addr_in = '0; bus_b.wdata = '0;

        // Read 0x155 returning 0xCABF
        row(1,0,10'h155,16'h0000,16'hCABF, 1,1,1,1,0,0,10'h000,16'h0000,16'h0);
        row(0,0,10'h000,16'h0000,16'hCABF, 0,1,1,0,0,0,10'h155,16'h0000,16'h0);
        row(0,0,10'h000,16'h0000,16'hCABF, 0,0,1,0,0,0,10'h155,16'h0000,16'h0);
        row(0,0,10'h000,16'h0000,16'hCABF, 0,0,1,0,0,0,10'h155,16'h0000,16'h0);
        row(0,0,10'h000,16'h0000,16'hCABF, 0,1,1,0,0,0,10'h155,16'hCABF,16'h0);
`ifdef SRAM_BUS_TURNAROUND_EN
        row(0,0,10'h000,16'h0000,16'hCABF, 1,1,1,0,0,0,10'h155,16'hCABF,16'h0);
`endif
        row(0,0,10'h000,16'h0000,16'hCABF, 1,1,1,1,1,0,10'h155,16'hCABF,16'h0);
        row(0,0,10'h000,16'h0000,16'hCABF, 1,1,1,1,0,0,10'h155,16'hCABF,16'h0);

        // Write 0x1234 to 0x3FF
        row(1,1,10'h3FF,16'h1234,16'h0000, 1,1,1,1,0,0,10'h155,16'hCABF,16'h0);
        row(0,0,10'h000,16'h0000,16'h0000, 0,1,1,0,0,1,10'h3FF,16'hCABF,16'h1234);
        row(0,0,10'h000,16'h0000,16'h0000, 0,1,0,0,0,1,10'h3FF,16'hCABF,16'h1234);
        row(0,0,10'h000,16'h0000,16'h0000, 0,1,0,0,0,1,10'h3FF,16'hCABF,16'h1234);
        row(0,0,10'h000,16'h0000,16'h0000, 0,1,1,0,0,1,10'h3FF,16'hCABF,16'h1234);
`ifdef SRAM_BUS_TURNAROUND_EN
        row(0,0,10'h000,16'h0000,16'h0000, 1,1,1,0,0,0,10'h3FF,16'hCABF,16'h0);
`endif
        row(0,0,10'h000,16'h0000,16'h0000, 1,1,1,1,0,0,10'h3FF,16'hCABF,16'h0);

        // Write 0x0001 to 0x002, then a pending read of 0x0AA
        row(1,1,10'h002,16'h0001,16'h5A5A, 1,1,1,1,0,0,10'h3FF,16'hCABF,16'h0);
        row(1,0,10'h0AA,16'h0000,16'h5A5A, 0,1,1,0,0,1,10'h002,16'hCABF,16'h0001);
        row(1,0,10'h0AA,16'h0000,16'h5A5A, 0,1,0,0,0,1,10'h002,16'hCABF,16'h0001);
        row(1,0,10'h0AA,16'h0000,16'h5A5A, 0,1,0,0,0,1,10'h002,16'hCABF,16'h0001);
        row(1,0,10'h0AA,16'h0000,16'h5A5A, 0,1,1,0,0,1,10'h002,16'hCABF,16'h0001);
`ifdef SRAM_BUS_TURNAROUND_EN
        row(1,0,10'h0AA,16'h0000,16'h5A5A, 1,1,1,0,0,0,10'h002,16'hCABF,16'h0);
`endif
        row(1,0,10'h0AA,16'h0000,16'h5A5A, 1,1,1,1,0,0,10'h002,16'hCABF,16'h0);
        row(0,0,10'h000,16'h0000,16'h5A5A, 0,1,1,0,0,0,10'h0AA,16'hCABF,16'h0);
        row(0,0,10'h000,16'h0000,16'h5A5A, 0,0,1,0,0,0,10'h0AA,16'hCABF,16'h0);
        row(0,0,10'h000,16'h0000,16'h5A5A, 0,0,1,0,0,0,10'h0AA,16'hCABF,16'h0);
        row(0,0,10'h000,16'h0000,16'h5A5A, 0,1,1,0,0,0,10'h0AA,16'h5A5A,16'h0);
`ifdef SRAM_BUS_TURNAROUND_EN
        row(0,0,10'h000,16'h0000,16'h5A5A, 1,1,1,0,0,0,10'h0AA,16'h5A5A,16'h0);
`endif
        row(0,0,10'h000,16'h0000,16'h5A5A, 1,1,1,1,1,0,10'h0AA,16'h5A5A,16'h0);
        row(0,0,10'h000,16'h0000,16'h5A5A, 1,1,1,1,0,0,10'h0AA,16'h5A5A,16'h0);

        // Read 0x011; requests while busy must be ignored
        row(1,0,10'h011,16'h0000,16'h1111, 1,1,1,1,0,0,10'h0AA,16'h5A5A,16'h0);
        row(0,0,10'h000,16'h0000,16'h1111, 0,1,1,0,0,0,10'h011,16'h5A5A,16'h0);
        row(1,1,10'h3AA,16'hFFFF,16'h1111, 0,0,1,0,0,0,10'h011,16'h5A5A,16'h0);
        row(1,0,10'h222,16'h0000,16'h1111, 0,0,1,0,0,0,10'h011,16'h5A5A,16'h0);
        row(0,0,10'h000,16'h0000,16'h1111, 0,1,1,0,0,0,10'h011,16'h1111,16'h0);
`ifdef SRAM_BUS_TURNAROUND_EN
        row(0,0,10'h000,16'h0000,16'h1111, 1,1,1,0,0,0,10'h011,16'h1111,16'h0);
`endif
        row(0,0,10'h000,16'h0000,16'h1111, 1,1,1,1,1,0,10'h011,16'h1111,16'h0);
        row(0,0,10'h000,16'h0000,16'h1111, 1,1,1,1,0,0,10'h011,16'h1111,16'h0);
        row(0,0,10'h000,16'h0000,16'h1111, 1,1,1,1,0,0,10'h011,16'h1111,16'h0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_idle_reset("reset");

        for (int i = 0; i < tbl.size(); i++) begin
            @(negedge clk);
            bus_a.req = tbl[i].req;
            bus_a.wr = tbl[i].wr;
            bus_a.addr_in = tbl[i].addr;
            bus_a.wdata = tbl[i].wdata;
            sd_a = tbl[i].sd;
            #1;
            chk("ncs", i, 32'(bus_a.ncs), 32'(tbl[i].ncs));
            chk("noe", i, 32'(bus_a.noe), 32'(tbl[i].noe));
            chk("nwe", i, 32'(bus_a.nwe), 32'(tbl[i].nwe));
            chk("ready", i, 32'(bus_a.ready), 32'(tbl[i].rdy));
            chk("rvalid", i, 32'(bus_a.rvalid), 32'(tbl[i].rv));
            chk("drive", i, 32'(dut_a.drive_q), 32'(tbl[i].drv));
            chk("addr", i, 32'(bus_a.sram_addr), 32'(tbl[i].ea));
            chk("rdata", i, 32'(bus_a.rdata), 32'(tbl[i].erd));
            if (tbl[i].drv) begin
                chk("wbus", i, 32'(data_a), 32'(tbl[i].ed));
            end
        end

        // Reset during the PULSE of a write, then a clean read
        @(negedge clk);
        bus_a.req = 1; bus_a.wr = 1; bus_a.addr_in = 10'h123;
        bus_a.wdata = 16'hA5A5;
        @(negedge clk);
        bus_a.req = 0;
        @(negedge clk);
        #1;
        chk("rst_pulse_nwe", 0, 32'(bus_a.nwe), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk_idle_reset("abort");
        bus_a.req = 1; bus_a.wr = 0; bus_a.addr_in = 10'h100;
        sd_a = 16'hBEEF;
        got = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            bus_a.req = 0;
            #1;
            if (bus_a.rvalid) begin
                got = k;
                break;
            end
        end
`ifdef SRAM_BUS_TURNAROUND_EN
        chk("post_rst_rv_lat", 0, 32'(got), 32'd6);
`else
        chk("post_rst_rv_lat", 0, 32'(got), 32'd5);
`endif
        chk("post_rst_rdata", 0, 32'(bus_a.rdata), 32'hBEEF);
        chk("post_rst_addr", 0, 32'(bus_a.sram_addr), 32'h100);

        // Slow timing instance: SETUP=3, PULSE=4, HOLD=2
`ifdef SRAM_BUS_TURNAROUND_EN
        rv_exp = 11;
`else
        rv_exp = 10;
`endif
        sd_b = 16'h0F0F;
        for (int c = 0; c <= 12; c++) begin
            @(negedge clk);
            bus_b.req = (c == 0);
            bus_b.addr_in = 10'h2A5;
            #1;
            chk("slow_ncs", c, 32'(bus_b.ncs), 32'(!(c >= 1 && c <= 9)));
            chk("slow_noe", c, 32'(bus_b.noe), 32'(!(c >= 4 && c <= 7)));
            chk("slow_nwe", c, 32'(bus_b.nwe), 32'd1);
            chk("slow_rvalid", c, 32'(bus_b.rvalid), 32'(c == rv_exp));
        end
        chk("slow_rdata", 0, 32'(bus_b.rdata), 32'h0F0F);
        chk("slow_addr", 0, 32'(bus_b.sram_addr), 32'h2A5);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/sram_bus_master.md
Name: sram_bus_master

Overview:
- FPGA-side initiator for the asynchronous 16-bit static-memory bus: ncs/noe/nwe, address, bidirectional data.
- Converts a single-word request/ready handshake from internal logic into bus cycles with parameterised setup/pulse/hold timing.
- Drives external SRAMs and memory-mapped peripherals, and is the bench driver for FPGA SRAM-bus slaves.

Parameters:
B, 15, data bus MSB index (bus width B+1)
AW, 10, address width
SETUP, 1, cycles ncs low before strobe; legal range 1..15
PULSE, 2, cycles noe/nwe low; legal range 1..15
HOLD, 1, cycles ncs low after strobe deasserts; legal range 1..15

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-high
req  input  1  access request
wr  input  1  1 = write, 0 = read; sampled with req
addr_in  input  AW  word address; sampled with req
wdata  input  B+1  write data; sampled with req
ready  output  1  high when a request can be accepted
rdata  output  B+1  read data; holds the last read value
rvalid  output  1  one-cycle pulse when rdata is updated
sram_addr  output  AW  bus address
sram_data  inout  B+1  bus data
ncs  output  1  chip select, active low
noe  output  1  output enable, active low
nwe  output  1  write enable, active low

Behaviour:
- All outputs and the data-bus drive enable are registered.
- Reset values:
  - ncs = noe = nwe = 1; sram_data tri-stated.
  - ready = 1, rvalid = 0, rdata = 0, sram_addr = 0.
  - State = IDLE, counter = 0.
- FSM states: IDLE -> SETUP -> PULSE -> HOLD -> IDLE.
- A down-counter is loaded with SETUP-1, PULSE-1 or HOLD-1 on entry to each state. A state is left when the counter is 0 at a clock edge.
- IDLE:
  - ready = 1.
  - Accept occurs at an edge where req & ready is true. On accept, latch wr, addr_in -> sram_addr, and wdata into the write register; go to SETUP.
  - req is ignored when ready = 0 (no queuing).
- SETUP: ncs = 0. For a write, data drive is enabled from the first SETUP cycle.
- PULSE:
  - ncs = 0.
  - Read: noe = 0.
  - Write: nwe = 0, data still driven.
- HOLD: ncs = 0, noe = nwe = 1. For a write, data is still driven through the last HOLD cycle.
- After HOLD: ncs = 1, data released, return to IDLE.
- Bus invariants:
  - sram_addr is stable from SETUP through HOLD and holds its value while IDLE.
  - noe and nwe are never low at the same time.
  - Data is driven only during write accesses.
- Read capture: rdata is registered from sram_data at the edge that ends the last PULSE cycle, while noe is still low.
- rvalid is high for exactly the first IDLE cycle after a read's HOLD. No rvalid is produced for writes.
- Latency: the access occupies SETUP+PULSE+HOLD cycles after the accept edge. ready returns to 1 in the following cycle. Back-to-back accepts are allowed in that cycle, unless the optional feature below is enabled.
- Reset mid-access: at the reset edge, abort immediately. All outputs take their reset values, no rvalid is produced, and the partial write is not retried.

Optional Feature:
- Macro: SRAM_BUS_TURNAROUND_EN.
- Defined:
  - Add a TURN state after HOLD: one cycle with ncs = noe = nwe = 1, bus tri-stated, ready = 0, then IDLE.
  - This guarantees at least one deselected, undriven cycle between consecutive accesses.
  - rvalid timing moves one cycle later, to the first IDLE cycle.
- Not defined: HOLD goes straight to IDLE as described above.

Test Plan:
- Read, defaults: accept at edge 0 with addr_in = 0x155; slave model drives 0xCABF while noe = 0 -> sram_addr = 0x155; ncs low cycles 1-4; noe low cycles 2-3; rdata = 0xCABF; rvalid pulses in cycle 5; nwe stays 1.
- Write, defaults: req, wr = 1, addr_in = 0x3FF, wdata = 0x1234 -> sram_data = 0x1234 during cycles 1-4; nwe low cycles 2-3 only; noe stays 1; bus Z in cycle 5; no rvalid.
- Back-to-back: write 0x0001 to 0x002, then a read held pending -> read accepted in the first ready cycle; ncs high for exactly one cycle between accesses. With SRAM_BUS_TURNAROUND_EN: ncs high for two cycles and bus Z in between.
- Timing parameters SETUP = 3, PULSE = 4, HOLD = 2, read -> ncs low 9 cycles; noe low cycles 4-7; rvalid in cycle 10.
- req asserted while ready = 0 -> ignored; no extra bus cycle; the first access completes unaffected.
- Reset asserted during PULSE of a write -> next cycle ncs = nwe = noe = 1, bus Z, ready = 1, rvalid = 0; a new read afterwards completes normally.
